// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between two byte-stream requesters (0: 8250 emulation TX,
// 1: debug console). Round-robin grant with burst-level locking so a multi-byte message
// from one source is never interleaved with the other. Issues one start pulse per byte and
// paces itself on the transmitter ready flag.
//
// Ports:
//   iClk, iRst           clock, asynchronous active-high reset
//   iData0/1, iValid0/1  requester byte and valid (held until the matching oTaken)
//   iLast0/1             current byte ends a message
//   oTaken0/1            one-cycle pulse: byte handed to the transmitter
//   iTxReady             transmitter idle and able to accept a byte
//   oTxData, oTxStart    byte and one-cycle start pulse to the transmitter
//   oGrant               one-hot current owner, 00 when idle
// All outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData0,
  input  logic [7:0] iData1,
  input  logic       iValid0,
  input  logic       iValid1,
  input  logic       iLast0,
  input  logic       iLast1,
  output logic       oTaken0,
  output logic       oTaken1,
  input  logic       iTxReady,
  output logic [7:0] oTxData,
  output logic       oTxStart,
  output logic [1:0] oGrant
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  // HOLD_CYCLES = 0 would give a zero-width counter; keep at least one bit.
  localparam int unsigned HoldW  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD_CYCLES);

  typedef enum logic [1:0] {StIdle, StGrant, StSettle} stateT;

  stateT             state;
  logic              lastOwner;  // also the current owner while granted
  logic              lastFlag;
  logic [BurstW-1:0] burstCnt;
  logic [HoldW-1:0]  holdCnt;

  logic       idlePick;
  logic       ownerValid;
  logic       ownerLast;
  logic [7:0] ownerData;

  // On contention the requester that did not own last wins; otherwise the lone requester.
  assign idlePick   = (iValid0 && iValid1) ? ~lastOwner : iValid1;
  assign ownerValid = lastOwner ? iValid1 : iValid0;
  assign ownerLast  = lastOwner ? iLast1  : iLast0;
  assign ownerData  = lastOwner ? iData1  : iData0;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= StIdle;
      lastOwner <= 1'b1;
      lastFlag  <= 1'b0;
      burstCnt  <= '0;
      holdCnt   <= '0;
      oTxData   <= 8'h00;
      oTxStart  <= 1'b0;
      oTaken0   <= 1'b0;
      oTaken1   <= 1'b0;
      oGrant    <= 2'b00;
    end else begin
      oTxStart <= 1'b0;
      oTaken0  <= 1'b0;
      oTaken1  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (iValid0 || iValid1) begin
            oGrant    <= idlePick ? 2'b10 : 2'b01;
            lastOwner <= idlePick;
            burstCnt  <= '0;
            holdCnt   <= '0;
            state     <= StGrant;
          end
        end
        StGrant: begin
          if (ownerValid) begin
            holdCnt <= '0;
            if (iTxReady) begin
              oTxData  <= ownerData;
              oTxStart <= 1'b1;
              oTaken0  <= ~lastOwner;
              oTaken1  <= lastOwner;
              lastFlag <= ownerLast;
              burstCnt <= burstCnt + 1'b1;
              state    <= StSettle;
            end
          end else if (holdCnt == HoldMax) begin
            oGrant <= 2'b00;
            state  <= StIdle;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        StSettle: begin
          // Requester inputs are ignored here: the owner's valid may still show the byte
          // just taken, and the transmitter may not have dropped ready yet.
          if (lastFlag || (burstCnt == BurstMax)) begin
            oGrant <= 2'b00;
            state  <= StIdle;
          end else begin
            state <= StGrant;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single FPGA UART transmitter between two byte-stream requesters: the 8250 emulation's TX output (requester 0) and a debug/monitor console stream (requester 1). The block sits between the requesters and `uartTx` inside the UART bridge. It grants the transmitter round-robin with burst-level locking, so multi-byte messages from one source are not interleaved with the other. It issues one start pulse per byte and paces itself on the transmitter's ready flag.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum bytes sent per grant; must be ≥1.
- `HOLD_CYCLES`, default 64: consecutive idle cycles (owner `iValid` low) tolerated before the grant is released; 0 means release on the first idle cycle.

Ports:
- `iClk` in 1: system clock, the only clock.
- `iRst` in 1: reset, asynchronous, active-high.
- `iData0`, `iData1` in 8: requester byte; must be stable while the matching `iValid` is high.
- `iValid0`, `iValid1` in 1: requester has a byte. Held until the matching `oTaken` is seen.
- `iLast0`, `iLast1` in 1: qualifies the current byte as the end of a message.
- `oTaken0`, `oTaken1` out 1: one-cycle pulse; the byte was handed to the transmitter.
- `iTxReady` in 1: transmitter idle and able to accept a byte.
- `oTxData` out 8: byte for the transmitter.
- `oTxStart` out 1: one-cycle start pulse to the transmitter.
- `oGrant` out 2: one-hot current owner; 00 when idle.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner selected, waiting for a byte.
  - SETTLE: one cycle after issuing a byte.
- Registers:
  - `lastOwner`: reset value 1, so requester 0 wins the first contention.
  - `burstCnt`: width $clog2(MAX_BURST+1).
  - `holdCnt`: width $clog2(HOLD_CYCLES+1).
- IDLE:
  - If exactly one `iValid` is high, grant that requester.
  - If both are high, grant the requester ≠ `lastOwner`.
  - On a grant: go to GRANT, set `oGrant` and `lastOwner`, clear `burstCnt` and `holdCnt`.
- GRANT:
  - Owner `iValid` high and `iTxReady` high: register the owner's data into `oTxData`, pulse `oTxStart` and the owner's `oTaken`, latch the owner's `iLast`, increment `burstCnt`, clear `holdCnt`, go to SETTLE.
  - Owner `iValid` high and `iTxReady` low: wait; clear `holdCnt`.
  - Owner `iValid` low: if `holdCnt` == HOLD_CYCLES, go to IDLE with `oGrant`=00; otherwise increment `holdCnt`.
- SETTLE:
  - Requester inputs are ignored in this state, so a stale `iValid` is never double-sent.
  - If the latched last flag is set or `burstCnt` == MAX_BURST, go to IDLE (`oGrant`=00). Otherwise go to GRANT.
- Non-owner requests are ignored until the grant returns to IDLE. The IDLE state always costs one cycle between owners.
- Transmitter contract: `iTxReady` falls no later than one cycle after `oTxStart`. SETTLE covers that cycle.

## Timing
- Reset values:
  - `oTxStart`, `oTaken0`, `oTaken1`: 0.
  - `oTxData`: 00.
  - `oGrant`: 00.
  - State: IDLE.
  - Counters: 0.
- Reset asserted mid-byte: returns to IDLE immediately. An already-issued start is owned by the transmitter, and no `oTaken` is produced after reset.
- All outputs are registered.
- Latency, request in IDLE at cycle n:
  - `oGrant` is valid at n+1.
  - If `iTxReady` is high at n+1, `oTxStart` and `oTaken` pulse at n+2.
- Pacing: after a start at cycle m (SETTLE), the earliest next GRANT evaluation is m+1 and the earliest next start is m+2, provided `iTxReady` is high.
- `oTaken`: exactly one pulse per byte, coincident with `oTxStart`. `oTxData` holds its value until the next start.
- A release and a new request in the same cycle: the request is evaluated in the following IDLE cycle.

## Test plan
- Single request: `iValid0`=1, `iData0`=0x41, `iLast0`=1, `iTxReady`=1 → `oGrant`=01 at n+1. `oTxStart`/`oTaken0` pulse at n+2 with `oTxData`=0x41. `oGrant`=00 at n+3.
- Contention after reset: both valid, bytes 0x30/0x31, each with last=1 → order 0x30 then 0x31. Repeat the pair → 0x30 before 0x31 again, since round-robin alternates by `lastOwner`.
- Burst lock: requester 0 sends 5 bytes with last only on the 5th, while requester 1 is continuously valid → all 5 bytes from requester 0 are contiguous, then requester 1 is granted. With MAX_BURST=3 instead → 3 bytes, then requester 1, then the remaining 2.
- Hold timeout (HOLD_CYCLES=4): owner drops valid without last → `oGrant` stays set for 4 cycles, then 00. Requester 1, pending, is granted one cycle later.
- Transmitter busy: hold `iTxReady`=0 for 100 cycles with owner valid → no start, no timeout, `oGrant` held. Raise ready → a single start follows.
- Async reset: assert `iRst` in SETTLE with both valid → all outputs 0 before the next clock edge. After release, requester 0 is granted first.
